// File: rtl/sgd_x_mem_write_engine_if.sv
// Bundle of the x-data intake, memory write command/data channels and status
// flags of the x-model write engine.
interface sgd_x_mem_write_engine_if;
  logic         x_data_send_back_start;
  logic [63:0]  x_data_send_back_addr;
  logic [31:0]  x_data_send_back_length;
  logic [511:0] x_data_in;
  logic         x_data_in_valid;
  logic         x_data_almost_full;
  logic         mem_wr_cmd_valid;
  logic         mem_wr_cmd_ready;
  logic [63:0]  mem_wr_cmd_addr;
  logic [31:0]  mem_wr_cmd_len;
  logic         mem_wr_data_valid;
  logic         mem_wr_data_ready;
  logic [511:0] mem_wr_data;
  logic         mem_wr_data_last;
  logic         x_write_done;
  logic         overflow_err;

  modport master (
    input  x_data_send_back_start, x_data_send_back_addr, x_data_send_back_length,
    input  x_data_in, x_data_in_valid,
    output x_data_almost_full,
    output mem_wr_cmd_valid, mem_wr_cmd_addr, mem_wr_cmd_len,
    input  mem_wr_cmd_ready,
    output mem_wr_data_valid, mem_wr_data, mem_wr_data_last,
    input  mem_wr_data_ready,
    output x_write_done, overflow_err
  );

  modport slave (
    output x_data_send_back_start, x_data_send_back_addr, x_data_send_back_length,
    output x_data_in, x_data_in_valid,
    input  x_data_almost_full,
    input  mem_wr_cmd_valid, mem_wr_cmd_addr, mem_wr_cmd_len,
    output mem_wr_cmd_ready,
    input  mem_wr_data_valid, mem_wr_data, mem_wr_data_last,
    output mem_wr_data_ready,
    input  x_write_done, overflow_err
  );
endinterface

// File: rtl/sgd_x_mem_write_engine.sv
// x-model write engine: buffers the 512-bit x stream in a FIFO and writes each
// job to memory as bursts that never cross a MAX_BURST_BYTES boundary.
module sgd_x_mem_write_engine #(
  parameter int unsigned FIFO_DEPTH      = 64,
  parameter int unsigned AF_MARGIN       = 16,
  parameter int unsigned MAX_BURST_BYTES = 4096
) (
  input  logic                            clk,
  input  logic                            rst_n,
  sgd_x_mem_write_engine_if.master        bus
);
  // state  | meaning
  // S_IDLE | no burst in flight; launches or retires the active job
  // S_CMD  | write command presented, addr/len held until accepted
  // S_DATA | streaming beats of the accepted burst from the FIFO
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_e;

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OFF_W = $clog2(MAX_BURST_BYTES);
  localparam logic [CNT_W-1:0] AF_LEVEL   = CNT_W'(FIFO_DEPTH - AF_MARGIN);
  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]      MAX_BURST  = 32'(MAX_BURST_BYTES);

  logic [511:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             af_q;
  logic             fifo_empty, fifo_full, push_ok, push_drop, pop;

  state_e      state_q, state_d;
  logic [63:0] cur_addr_q, cur_addr_d;
  logic [31:0] remaining_q, remaining_d;
  logic        job_vld_q, job_vld_d;
  logic        pend_vld_q, pend_vld_d;
  logic [63:0] pend_addr_q, pend_addr_d;
  logic [31:0] pend_len_q, pend_len_d;
  logic [31:0] burst_q, burst_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;

  logic [31:0] room, burst;
  logic        cmd_valid, data_valid, job_clear, job_free;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_LEVEL);
  assign push_ok    = bus.x_data_in_valid && !fifo_full;
  assign push_drop  = bus.x_data_in_valid && fifo_full;
  assign pop        = data_valid && bus.mem_wr_data_ready;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= bus.x_data_in;
  end

  // almost_full is registered from the next count so it tracks count_q exactly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      af_q    <= (count_d >= AF_LEVEL);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      job_vld_q   <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_len_q  <= '0;
      burst_q     <= '0;
      beat_cnt_q  <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      job_vld_q   <= job_vld_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      pend_len_q  <= pend_len_d;
      burst_q     <= burst_d;
      beat_cnt_q  <= beat_cnt_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    job_vld_d   = job_vld_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    pend_len_d  = pend_len_q;
    burst_d     = burst_q;
    beat_cnt_d  = beat_cnt_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    cmd_valid   = 1'b0;
    data_valid  = 1'b0;
    job_clear   = 1'b0;
    room        = MAX_BURST - 32'(cur_addr_q[OFF_W-1:0]);
    burst       = (remaining_q < room) ? remaining_q : room;

    unique case (state_q)
      S_IDLE: begin
        if (job_vld_q) begin
          if (remaining_q == '0) begin
            done_d    = 1'b1;
            job_clear = 1'b1;
          end else begin
            state_d = S_CMD;
          end
        end
      end
      S_CMD: begin
        cmd_valid = 1'b1;
        if (bus.mem_wr_cmd_ready) begin
          burst_d    = burst;
          beat_cnt_d = burst >> 6;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        data_valid = !fifo_empty;
        if (data_valid && bus.mem_wr_data_ready) begin
          beat_cnt_d = beat_cnt_q - 32'd1;
          if (beat_cnt_q == 32'd1) begin
            cur_addr_d  = cur_addr_q + 64'(burst_q);
            remaining_d = remaining_q - burst_q;
            if (remaining_q == burst_q) begin
              done_d    = 1'b1;
              job_clear = 1'b1;
              state_d   = S_IDLE;
            end else begin
              state_d = S_CMD;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // a retiring job frees the active slot in the same cycle for the pending one
    job_free = !job_vld_q || job_clear;
    if (job_free) begin
      job_vld_d = 1'b0;
      if (pend_vld_q) begin
        cur_addr_d  = pend_addr_q;
        remaining_d = pend_len_q;
        job_vld_d   = 1'b1;
        pend_vld_d  = 1'b0;
      end
    end

    if (bus.x_data_send_back_start) begin
      if (job_free && !pend_vld_q) begin
        cur_addr_d  = bus.x_data_send_back_addr;
        remaining_d = bus.x_data_send_back_length;
        job_vld_d   = 1'b1;
      end else if (!pend_vld_d) begin
        pend_addr_d = bus.x_data_send_back_addr;
        pend_len_d  = bus.x_data_send_back_length;
        pend_vld_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (push_drop) ovf_d = 1'b1;
  end

  assign bus.x_data_almost_full = af_q;
  assign bus.mem_wr_cmd_valid   = cmd_valid;
  assign bus.mem_wr_cmd_addr    = cmd_valid ? cur_addr_q : '0;
  assign bus.mem_wr_cmd_len     = cmd_valid ? burst : '0;
  assign bus.mem_wr_data_valid  = data_valid;
  assign bus.mem_wr_data        = data_valid ? fifo_mem[rd_ptr_q] : '0;
  assign bus.mem_wr_data_last   = data_valid && (beat_cnt_q == 32'd1);
  assign bus.x_write_done       = done_q;
  assign bus.overflow_err       = ovf_q;
endmodule

// File: tb/tb_sgd_x_mem_write_engine.sv
// Directed bench for the x-model write engine: memory-side monitor checks every
// command and beat against hand-listed expectations.
module tb_sgd_x_mem_write_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sgd_x_mem_write_engine_if bus_if ();
  sgd_x_mem_write_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

  typedef struct {
    logic [63:0] a;
    logic [31:0] l;
  } cmd_t;

  cmd_t exp_cmd_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   push_seq = 0;
  int   exp_seq = 0;
  int   beats_left = 0;
  int   model_cnt = 0;
  int   af_rises = 0;
  int   last_last_cyc = 0;
  int   last_done_cyc = 0;
  logic af_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // memory-side monitor, sampled on the falling edge
  always @(negedge clk) begin
    cmd_t e;
    cyc++;
    if (!rst_n) begin
      beats_left = 0;
      model_cnt  = 0;
      exp_seq    = push_seq;
      af_prev    = 1'b0;
    end else begin
      if (bus_if.x_data_almost_full && !af_prev) begin
        af_rises++;
        chk("af_rise_level", 64'(model_cnt), 64'd48);
      end
      if (!bus_if.x_data_almost_full && af_prev) chk("af_fall_level", 64'(model_cnt), 64'd47);
      af_prev = bus_if.x_data_almost_full;
      if (bus_if.mem_wr_cmd_valid && bus_if.mem_wr_cmd_ready) begin
        chk("cmd_expected", 64'(exp_cmd_q.size() != 0), 64'd1);
        if (exp_cmd_q.size() != 0) begin
          e = exp_cmd_q.pop_front();
          chk("cmd_addr", bus_if.mem_wr_cmd_addr, e.a);
          chk("cmd_len", 64'(bus_if.mem_wr_cmd_len), 64'(e.l));
        end
        beats_left = int'(bus_if.mem_wr_cmd_len >> 6);
      end
      if (bus_if.mem_wr_data_valid && bus_if.mem_wr_data_ready) begin
        chk("beat_in_burst", 64'(beats_left != 0), 64'd1);
        chk("beat_data_lo", bus_if.mem_wr_data[63:0], 64'(exp_seq));
        chk("beat_data_hi", bus_if.mem_wr_data[511:448], 64'(exp_seq));
        chk("beat_last", 64'(bus_if.mem_wr_data_last), 64'(beats_left == 1));
        if (bus_if.mem_wr_data_last) last_last_cyc = cyc;
        exp_seq++;
        if (beats_left > 0) beats_left--;
        model_cnt--;
      end
      if (bus_if.x_data_in_valid && model_cnt < 64) model_cnt++;
      if (bus_if.x_write_done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_job(input logic [63:0] a, input logic [31:0] l);
    bus_if.x_data_send_back_start  = 1'b1;
    bus_if.x_data_send_back_addr   = a;
    bus_if.x_data_send_back_length = l;
    tick();
    bus_if.x_data_send_back_start  = 1'b0;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.x_data_in_valid = 1'b1;
      bus_if.x_data_in       = {8{64'(push_seq)}};
      push_seq++;
      tick();
    end
    bus_if.x_data_in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic chk_outputs_idle(input string pfx);
    chk({pfx, "_cmd_valid"}, 64'(bus_if.mem_wr_cmd_valid), 64'd0);
    chk({pfx, "_data_valid"}, 64'(bus_if.mem_wr_data_valid), 64'd0);
    chk({pfx, "_data_last"}, 64'(bus_if.mem_wr_data_last), 64'd0);
    chk({pfx, "_af"}, 64'(bus_if.x_data_almost_full), 64'd0);
    chk({pfx, "_done"}, 64'(bus_if.x_write_done), 64'd0);
    chk({pfx, "_ovf"}, 64'(bus_if.overflow_err), 64'd0);
  endtask

  initial begin
    bus_if.x_data_send_back_start  = 1'b0;
    bus_if.x_data_send_back_addr   = '0;
    bus_if.x_data_send_back_length = '0;
    bus_if.x_data_in               = '0;
    bus_if.x_data_in_valid         = 1'b0;
    bus_if.mem_wr_cmd_ready        = 1'b0;
    bus_if.mem_wr_data_ready       = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk_outputs_idle("rst");
    rst_n = 1'b1;
    tick();

    // 1: aligned 256-byte job
    bus_if.mem_wr_cmd_ready  = 1'b1;
    bus_if.mem_wr_data_ready = 1'b1;
    exp_cmd_q.push_back('{64'h1000, 32'd256});
    start_job(64'h1000, 32'd256);
    push_n(4);
    wait_done(1, 50, "t1_done_seen");
    repeat (3) tick();
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    chk("t1_done_lag", 64'(last_done_cyc - last_last_cyc), 64'd1);
    chk("t1_cmds_left", 64'(exp_cmd_q.size()), 64'd0);

    // 2: job straddling a 4 KiB boundary
    exp_cmd_q.push_back('{64'h0F80, 32'd128});
    exp_cmd_q.push_back('{64'h1000, 32'd384});
    start_job(64'h0F80, 32'd512);
    push_n(8);
    wait_done(2, 50, "t2_done_seen");
    repeat (3) tick();
    chk("t2_done_cnt", 64'(done_cnt), 64'd2);
    chk("t2_done_lag", 64'(last_done_cyc - last_last_cyc), 64'd1);
    chk("t2_cmds_left", 64'(exp_cmd_q.size()), 64'd0);

    // 3: 16 KiB job, toggling data_ready, producer throttled by almost_full
    for (int i = 0; i < 4; i++) exp_cmd_q.push_back('{64'(i * 4096), 32'd4096});
    start_job(64'h0, 32'd16384);
    fork
      begin : producer
        int sent, n;
        sent = 0;
        n = 0;
        while (sent < 256 && n < 5000) begin
          if (!bus_if.x_data_almost_full) begin
            bus_if.x_data_in_valid = 1'b1;
            bus_if.x_data_in       = {8{64'(push_seq)}};
            push_seq++;
            sent++;
          end else begin
            bus_if.x_data_in_valid = 1'b0;
          end
          tick();
          n++;
        end
        bus_if.x_data_in_valid = 1'b0;
        chk("t3_words_sent", 64'(sent), 64'd256);
      end
      begin : consumer
        int n;
        n = 0;
        while (done_cnt < 3 && n < 5000) begin
          bus_if.mem_wr_data_ready = ~bus_if.mem_wr_data_ready;
          tick();
          n++;
        end
        bus_if.mem_wr_data_ready = 1'b1;
      end
    join
    wait_done(3, 20, "t3_done_seen");
    repeat (3) tick();
    chk("t3_done_cnt", 64'(done_cnt), 64'd3);
    chk("t3_beats", 64'(exp_seq), 64'd268);
    chk("t3_ovf", 64'(bus_if.overflow_err), 64'd0);
    chk("t3_af_seen", 64'(af_rises != 0), 64'd1);
    chk("t3_cmds_left", 64'(exp_cmd_q.size()), 64'd0);

    // 4: command channel stalled for 10 cycles
    bus_if.mem_wr_cmd_ready = 1'b0;
    exp_cmd_q.push_back('{64'h2000, 32'd128});
    push_n(2);
    start_job(64'h2000, 32'd128);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t4_cmd_valid", 64'(bus_if.mem_wr_cmd_valid), 64'd1);
      chk("t4_cmd_addr", bus_if.mem_wr_cmd_addr, 64'h2000);
      chk("t4_cmd_len", 64'(bus_if.mem_wr_cmd_len), 64'd128);
      chk("t4_no_beat", 64'(bus_if.mem_wr_data_valid), 64'd0);
      tick();
    end
    bus_if.mem_wr_cmd_ready = 1'b1;
    wait_done(4, 50, "t4_done_seen");
    repeat (3) tick();
    chk("t4_done_cnt", 64'(done_cnt), 64'd4);

    // 5: pending job queued, third start dropped
    exp_cmd_q.push_back('{64'h4000, 32'd128});
    exp_cmd_q.push_back('{64'h5000, 32'd64});
    start_job(64'h4000, 32'd128);
    repeat (3) tick();
    chk("t5_ovf_before", 64'(bus_if.overflow_err), 64'd0);
    start_job(64'h5000, 32'd64);
    start_job(64'h6000, 32'd64);
    chk("t5_ovf_after", 64'(bus_if.overflow_err), 64'd1);
    push_n(3);
    wait_done(6, 50, "t5_done_seen");
    repeat (6) tick();
    chk("t5_done_cnt", 64'(done_cnt), 64'd6);
    chk("t5_cmds_left", 64'(exp_cmd_q.size()), 64'd0);

    // 6a: zero-length job
    start_job(64'h7000, 32'd0);
    wait_done(7, 20, "t6_zero_done_seen");
    repeat (4) tick();
    chk("t6_zero_done_cnt", 64'(done_cnt), 64'd7);
    chk("t6_zero_no_cmd", 64'(bus_if.mem_wr_cmd_valid), 64'd0);

    // 6b: reset in the middle of a data phase
    exp_cmd_q.push_back('{64'h8000, 32'd256});
    start_job(64'h8000, 32'd256);
    push_n(2);
    repeat (3) tick();
    bus_if.mem_wr_data_ready = 1'b0;
    push_n(3);
    chk("t6_mid_data_valid", 64'(bus_if.mem_wr_data_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    chk_outputs_idle("t6_rst");
    rst_n = 1'b1;
    exp_cmd_q.delete();
    repeat (5) tick();
    chk("t6_no_done", 64'(done_cnt), 64'd7);
    chk("t6_fifo_empty", 64'(bus_if.mem_wr_data_valid), 64'd0);
    bus_if.mem_wr_data_ready = 1'b1;
    exp_cmd_q.push_back('{64'h9000, 32'd64});
    start_job(64'h9000, 32'd64);
    push_n(1);
    wait_done(8, 50, "t6_after_rst_done_seen");
    repeat (3) tick();
    chk("t6_after_rst_done_cnt", 64'(done_cnt), 64'd8);
    chk("t6_cmds_left", 64'(exp_cmd_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
